// File: rtl/motor_pkg.sv
// Shared state encoding and default timing constants for the stepper pulse generator.
// Imported by the RTL and by the bench.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DECEL = 2'd3
  } state_t;

  localparam int unsigned DEF_PW         = 16;
  localparam logic [15:0] DEF_MAX_PERIOD = 16'd16000;
  localparam logic [15:0] DEF_MIN_PERIOD = 16'd2000;
  localparam logic [15:0] DEF_ACCEL      = 16'd500;
  localparam logic [15:0] DEF_PULSE_W    = 16'd100;
  localparam logic [15:0] DEF_DIR_SETUP  = 16'd200;

endpackage

// File: rtl/step_ramp.sv
// Step period register with saturating accelerate/decelerate updates.
// load_max has priority over decel_inc, which has priority over accel_dec.
module step_ramp
  import motor_pkg::*;
#(
  parameter int unsigned     PW         = DEF_PW,
  parameter logic [PW-1:0]   MAX_PERIOD = DEF_MAX_PERIOD,
  parameter logic [PW-1:0]   MIN_PERIOD = DEF_MIN_PERIOD,
  parameter logic [PW-1:0]   ACCEL      = DEF_ACCEL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accel_dec,
  input  logic          decel_inc,
  input  logic          load_max,
  output logic [PW-1:0] period
);

  logic [PW:0]   sum;
  logic [PW:0]   diff;
  logic [PW-1:0] period_d;

  // One extra bit so neither the add nor the subtract can wrap before clamping.
  always_comb begin
    sum      = {1'b0, period} + {1'b0, ACCEL};
    diff     = {1'b0, period} - {1'b0, ACCEL};
    period_d = period;
    if (load_max) begin
      period_d = MAX_PERIOD;
    end else if (decel_inc) begin
      period_d = (sum >= {1'b0, MAX_PERIOD}) ? MAX_PERIOD : sum[PW-1:0];
    end else if (accel_dec) begin
      period_d = (diff[PW] || (diff[PW-1:0] <= MIN_PERIOD)) ? MIN_PERIOD : diff[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= MAX_PERIOD;
    end else begin
      period <= period_d;
    end
  end

endmodule

// File: rtl/motor_step_gen.sv
// Stepper driver front end: linear period ramp, direction-setup delay and
// registered STEP/DIR_OUT/DRV_ENn outputs, driven by the en/dir command pair.
module motor_step_gen
  import motor_pkg::*;
#(
  parameter int unsigned   PW         = DEF_PW,
  parameter logic [PW-1:0] MAX_PERIOD = DEF_MAX_PERIOD,
  parameter logic [PW-1:0] MIN_PERIOD = DEF_MIN_PERIOD,
  parameter logic [PW-1:0] ACCEL      = DEF_ACCEL,
  parameter logic [PW-1:0] PULSE_W    = DEF_PULSE_W,
  parameter logic [PW-1:0] DIR_SETUP  = DEF_DIR_SETUP
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          en,
  input  logic          dir,
  output logic          STEP,
  output logic          DIR_OUT,
  output logic          DRV_ENn,
  output logic          busy,
  output logic          at_speed,
  output logic [PW-1:0] step_cnt,
  output state_t        dbg_state
);

  localparam logic [PW-1:0] SETUP_LAST = DIR_SETUP - PW'(1);

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] scnt_q, scnt_d;
  logic [PW-1:0] period;
  logic [PW:0]   cnt_p1;
  logic          dir_d, drv_enn_d, step_d, cnt_inc;
  logic          accel_dec, decel_inc, load_max;
  logic          boundary, stop_req, at_max, winding_down;

  step_ramp #(
    .PW         (PW),
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .ACCEL      (ACCEL)
  ) u_ramp (
    .clk       (CLK),
    .rst_n     (RSTn),
    .accel_dec (accel_dec),
    .decel_inc (decel_inc),
    .load_max  (load_max),
    .period    (period)
  );

  assign cnt_p1       = {1'b0, cnt_q} + (PW+1)'(1);
  assign boundary     = (cnt_p1 == {1'b0, period});
  assign stop_req     = !en || (dir != DIR_OUT);
  assign at_max       = (period >= MAX_PERIOD);
  assign winding_down = (state_q == DECEL) || stop_req;

  assign busy      = (state_q != IDLE);
  assign at_speed  = (state_q == RUN) && (period == MIN_PERIOD);
  assign dbg_state = state_q;

  // cnt_inc marks every edge that starts a new step, so step_cnt counts STEP rises.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    dir_d     = DIR_OUT;
    drv_enn_d = DRV_ENn;
    cnt_inc   = 1'b0;
    accel_dec = 1'b0;
    decel_inc = 1'b0;
    load_max  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          drv_enn_d = 1'b0;
          if (dir == DIR_OUT) begin
            state_d  = RUN;
            cnt_d    = '0;
            load_max = 1'b1;
            cnt_inc  = 1'b1;
          end else begin
            state_d = SETUP;
            dir_d   = dir;
            scnt_d  = '0;
          end
        end
      end
      SETUP: begin
        scnt_d = scnt_q + PW'(1);
        if (!en) begin
          state_d   = IDLE;
          drv_enn_d = 1'b1;
        end else if (scnt_q == SETUP_LAST) begin
          state_d  = RUN;
          cnt_d    = '0;
          load_max = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      RUN, DECEL: begin
        if (!boundary) begin
          cnt_d = cnt_p1[PW-1:0];
        end else begin
          cnt_d = '0;
          if (winding_down && at_max) begin
            state_d   = IDLE;
            drv_enn_d = 1'b1;
            load_max  = 1'b1;
          end else if (winding_down) begin
            state_d   = DECEL;
            decel_inc = 1'b1;
            cnt_inc   = 1'b1;
          end else begin
            accel_dec = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // STEP is the registered image of the next counter value, hence glitch-free.
    step_d = ((state_d == RUN) || (state_d == DECEL)) && (cnt_d < PULSE_W);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scnt_q   <= '0;
      STEP     <= 1'b0;
      DIR_OUT  <= 1'b0;
      DRV_ENn  <= 1'b1;
      step_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      STEP    <= step_d;
      DIR_OUT <= dir_d;
      DRV_ENn <= drv_enn_d;
      if (cnt_inc) begin
        step_cnt <= step_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_motor_step_gen.sv
// Bench for motor_step_gen: a step-level reference model predicts every STEP rise
// (time, direction, at_speed, step count); a monitor checks each observed rise.
module tb_motor_step_gen;
  import motor_pkg::*;

  localparam int PW       = 16;
  localparam int T_MAX    = 16;
  localparam int T_MIN    = 4;
  localparam int T_ACC    = 4;
  localparam int T_PW     = 2;
  localparam int T_SETUP  = 3;
  localparam int CLK_HALF = 5;
  localparam int EW       = 50;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          dir   = 1'b0;
  logic          step, dir_out, drv_enn, busy, at_speed;
  logic [PW-1:0] step_cnt;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  // Each entry: {rise time[31:0], dir_out, at_speed, step_cnt[15:0]}
  logic [EW-1:0] exp_q[$];
  int   model_cnt = 0;
  logic model_dir = 1'b0;
  bit   mon_on    = 1'b0;

  always #CLK_HALF clk = ~clk;

  motor_step_gen #(
    .PW         (PW),
    .MAX_PERIOD (16'(T_MAX)),
    .MIN_PERIOD (16'(T_MIN)),
    .ACCEL      (16'(T_ACC)),
    .PULSE_W    (16'(T_PW)),
    .DIR_SETUP  (16'(T_SETUP))
  ) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .en        (en),
    .dir       (dir),
    .STEP      (step),
    .DIR_OUT   (dir_out),
    .DRV_ENn   (drv_enn),
    .busy      (busy),
    .at_speed  (at_speed),
    .step_cnt  (step_cnt),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: thinks in whole steps, sampling commands only where a step ends.
  initial begin : ref_model
    int p;
    bit decel;
    bit go;
    wait (rst_n === 1'b1);
    forever begin
      @(posedge clk);
      if (en) begin
        go = 1'b1;
        if (dir != model_dir) begin
          model_dir = dir;
          for (int k = 0; k < T_SETUP; k++) begin
            @(posedge clk);
            if (!en) begin
              go = 1'b0;
              break;
            end
          end
        end
        if (go) begin
          p     = T_MAX;
          decel = 1'b0;
          forever begin
            model_cnt = (model_cnt + 1) % 65536;
            exp_q.push_back({32'($time), model_dir, (p == T_MIN) && !decel, 16'(model_cnt)});
            repeat (p) @(posedge clk);
            if (decel || !en || (dir != model_dir)) begin
              if (p >= T_MAX) break;
              decel = 1'b1;
              p = (p + T_ACC > T_MAX) ? T_MAX : p + T_ACC;
            end else begin
              p = (p - T_ACC < T_MIN) ? T_MIN : p - T_ACC;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    logic          prev = 1'b0;
    int            t_rise = 0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (step && !prev) begin
          t_rise = int'($time) - CLK_HALF;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step: rise at %0d with no step predicted", t_rise);
          end else begin
            e = exp_q.pop_front();
            check("rise_time", t_rise, int'(e[49:18]));
            check("dir_out", int'(dir_out), int'(e[17]));
            check("at_speed", int'(at_speed), int'(e[16]));
            check("step_cnt", int'(step_cnt), int'(e[15:0]));
            check("drv_enn_run", int'(drv_enn), 0);
          end
        end
        if (!step && prev) begin
          check("pulse_width", int'($time) - CLK_HALF - t_rise, T_PW * 2 * CLK_HALF);
        end
      end
      prev = step;
    end
  end

  task automatic drain(input string name);
    int n;
    n  = 0;
    en = 1'b0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_drv_enn"}, int'(drv_enn), 1);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_step_cnt"}, int'(step_cnt), model_cnt);
    check({name, "_dir_out"}, int'(dir_out), int'(model_dir));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int hold;
    int n;

    rst_n = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_dir_out", int'(dir_out), 0);
    check("reset_drv_enn", int'(drv_enn), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_at_speed", int'(at_speed), 0);
    check("reset_step_cnt", int'(step_cnt), 0);
    check("reset_state", int'(dbg_state), int'(IDLE));
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Ramp up to cruise, then drop en mid-step.
    en  = 1'b1;
    dir = 1'b0;
    repeat (80) @(negedge clk);
    check("cruise_at_speed", int'(at_speed), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    base = int'(step_cnt);
    drain("stop");
    check("stop_delta", int'(step_cnt) - base, 3);

    // Direction reversal at cruise with en held.
    en  = 1'b1;
    dir = 1'b0;
    repeat (70) @(negedge clk);
    dir = 1'b1;
    repeat (120) @(negedge clk);
    check("reverse_dir_out", int'(dir_out), 1);
    drain("reverse");

    // Single-cycle en pulse in the current direction.
    base = int'(step_cnt);
    en   = 1'b1;
    dir  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n  = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("pulse_busy_cycles", n, T_MAX);
    check("pulse_delta", int'(step_cnt) - base, 1);
    drain("pulse");

    // en withdrawn while the direction-setup delay is running.
    hold = $urandom_range(1, T_SETUP);
    en   = 1'b1;
    dir  = 1'b0;
    repeat (hold) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_dir_out", int'(dir_out), 0);
    check("abort_drv_enn", int'(drv_enn), 1);
    check("abort_busy", int'(busy), 0);
    drain("abort");

    // Random command sequences.
    for (int i = 0; i < 30; i++) begin
      en  = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    drain("random");

    // Asynchronous reset in the middle of a STEP pulse.
    en  = 1'b1;
    dir = model_dir;
    n   = 0;
    while (!step && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("pre_reset_step", int'(step), 1);
    mon_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_step", int'(step), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_step_cnt", int'(step_cnt), 0);
    check("async_rst_drv_enn", int'(drv_enn), 1);
    check("async_rst_dir_out", int'(dir_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
